// File: rtl/uart_pkg.sv
// Shared UART constants used by the RX and TX blocks.
// Defines the FSM state codes, the default bit period and the data width.
package uart_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int CLK_PER_BIT_DEF = 868;
  localparam int UART_DW         = 8;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; head reads 0 while empty.
// Pops on an empty FIFO are ignored; a push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign count   = count_q;
  assign head    = empty ? '0 : mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_buffer.sv
// UART receiver (8N1, or 8E1 when UART_PARITY_EN is defined) feeding a receive FIFO.
// Bytes with a bad stop bit or bad parity are discarded and flagged with a one-cycle pulse.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int DEPTH       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  input  logic               rd_en,
  output logic [UART_DW-1:0] rd_data,
  output logic               empty,
  output logic               full,
  output logic               overrun,
  output logic               frame_err,
  output logic               parity_err
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);

  logic               sync1_q, rx_s_q;
  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [UART_DW-1:0] shreg_q, shreg_d;
  logic               stop_smp, par_bad, push_req, drop;
  logic               frame_err_q, overrun_q;
  logic [AW:0]        fifo_count;
`ifdef UART_PARITY_EN
  logic               par_q, par_d, parity_err_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    stop_smp = 1'b0;
`ifdef UART_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[UART_DW-1:1]};
          idx_d   = idx_q + 1'b1;
`ifdef UART_PARITY_EN
          if (idx_q == 3'(UART_DW - 1)) state_d = ST_PARITY;
`else
          if (idx_q == 3'(UART_DW - 1)) state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          stop_smp = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A low stop bit wins over a parity mismatch, so parity is only judged when stop==1.
`ifdef UART_PARITY_EN
  assign par_bad = stop_smp && rx_s_q && (par_q != ^shreg_q);
`else
  assign par_bad = 1'b0;
`endif
  assign push_req = stop_smp && rx_s_q && !par_bad;
  assign drop     = push_req && (fifo_count == (AW+1)'(DEPTH)) && !rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rxd;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= stop_smp && !rx_s_q;
      overrun_q   <= overrun_q || drop;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= par_bad;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  sync_fifo #(
    .WIDTH (UART_DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (shreg_q),
    .pop       (rd_en),
    .head      (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Randomised bench for uart_rx_buffer: serialises frames onto rxd and compares against a queue model.
// Define UART_PARITY_EN for both bench and RTL to exercise the 8E1 frame.
module tb_uart_rx_buffer;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Stop sample edge counted from the first edge after the start bit is driven:
  // 2 synchroniser edges, 1 IDLE detect edge, half a bit to mid-start, then one bit per remaining bit.
  localparam int STOP_EDGE = 3 + CPB/2 + (NBITS-1)*CPB;
  localparam int C_STOP    = STOP_EDGE - (1 + CPB*(NBITS-1));

  logic       clk = 1'b0;
  logic       rst, rxd, rd_en;
  logic [7:0] rd_data;
  logic       empty, full, overrun, frame_err, parity_err;

  int n_tests = 0, n_fail = 0;
  int fe_seen = 0, pe_seen = 0, fe_exp = 0, pe_exp = 0;
  logic [7:0] q_m[$];
  bit ovr_m;

  uart_rx_buffer #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .overrun(overrun),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_seen++;
    if (parity_err === 1'b1) pe_seen++;
  end

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rxd = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q_m.delete();
    ovr_m = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".empty"},   empty,   q_m.size() == 0);
    chk({tag, ".full"},    full,    q_m.size() == DEPTH);
    chk({tag, ".overrun"}, overrun, ovr_m);
    chk({tag, ".rd_data"}, rd_data, (q_m.size() == 0) ? 0 : q_m[0]);
    chk({tag, ".fe_pulses"}, fe_seen, fe_exp);
    chk({tag, ".pe_pulses"}, pe_seen, pe_exp);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par,
                            input bit pop_at_stop, input bit chk_edge);
    logic [NBITS-1:0] bits;
    int  sz;
    bit  popped;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_PARITY_EN
    bits[9] = (^d) ^ bad_par;
`endif
    bits[NBITS-1] = ~bad_stop;
    for (int b = 0; b < NBITS; b++) begin
      rxd = bits[b];
      for (int c = 0; c < CPB; c++) begin
        if (b == NBITS-1 && c == C_STOP) begin
          if (pop_at_stop) rd_en = 1'b1;
          if (chk_edge) chk("empty_before_stop_edge", empty, 1);
        end
        if (b == NBITS-1 && c == C_STOP+1) begin
          rd_en = 1'b0;
          if (chk_edge) chk("empty_after_stop_edge", empty, 0);
        end
        @(negedge clk);
      end
    end
    rxd = 1'b1;
    sz = q_m.size();
    popped = pop_at_stop && sz > 0;
    if (popped) void'(q_m.pop_front());
    if (bad_stop) fe_exp++;
`ifdef UART_PARITY_EN
    else if (bad_par) pe_exp++;
`endif
    else if (sz < DEPTH || popped) q_m.push_back(d);
    else ovr_m = 1'b1;
    if (bad_stop) repeat (2*CPB) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag);
    if (q_m.size() == 0) begin
      chk({tag, ".empty"}, empty, 1);
      chk({tag, ".rd_data"}, rd_data, 0);
    end else begin
      chk({tag, ".empty"}, empty, 0);
      chk({tag, ".rd_data"}, rd_data, q_m[0]);
      void'(q_m.pop_front());
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset.empty", empty, 1);
    chk("reset.full", full, 0);
    chk("reset.rd_data", rd_data, 0);
    chk("reset.overrun", overrun, 0);
    chk("reset.frame_err", frame_err, 0);
    chk("reset.parity_err", parity_err, 0);

    // single clean byte, push latency and pop
    send_frame(8'h55, 0, 0, 0, 1);
    check_status("t1");
    pop_chk("t1.pop");
    check_status("t1.after_pop");
    pop_chk("t1.pop_empty");
    check_status("t1.empty_pop_ignored");

    // start glitch
    rxd = 1'b0; repeat (4) @(negedge clk);
    rxd = 1'b1; repeat (3*CPB) @(negedge clk);
    check_status("t2.glitch");
    send_frame(8'hC9, 0, 0, 0, 0);
    check_status("t2.after_glitch");
    pop_chk("t2.pop");

    // framing error
    send_frame(8'hA3, 1, 0, 0, 0);
    check_status("t3.frame_err");

    // fill past capacity
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(8'(i), 0, 0, 0, 0);
      if (i == DEPTH-1) check_status("t4.full");
    end
    check_status("t4.overrun");
    for (int i = 0; i <= DEPTH; i++) pop_chk("t4.drain");
    check_status("t4.drained");

    // push and pop together while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 0, 0, 0, 0);
    check_status("t5.full");
    send_frame(8'h77, 0, 0, 1, 0);
    check_status("t5.push_pop_full");
    while (q_m.size() > 0) pop_chk("t5.drain");
    check_status("t5.drained");

    // reset in the middle of a data bit stream
    rxd = 1'b0; repeat (CPB) @(negedge clk);
    rxd = 1'b1; repeat (CPB) @(negedge clk);
    rxd = 1'b0; repeat (CPB + CPB/2) @(negedge clk);
    do_reset();
    repeat (3*CPB) @(negedge clk);
    check_status("t6.after_rst");
    send_frame(8'h3C, 0, 0, 0, 0);
    check_status("t6.rx");
    pop_chk("t6.pop");
    check_status("t6.done");

`ifdef UART_PARITY_EN
    send_frame(8'h07, 0, 1, 0, 0);
    check_status("t7.parity_err");
    send_frame(8'h07, 1, 1, 0, 0);
    check_status("t7.frame_over_parity");
`endif

    // randomised traffic
    for (int n = 0; n < 40; n++) begin
      bit bs, bp, ps;
      bs = ($urandom_range(0, 7) == 0);
`ifdef UART_PARITY_EN
      bp = ($urandom_range(0, 5) == 0);
`else
      bp = 1'b0;
`endif
      ps = ($urandom_range(0, 3) == 0);
      send_frame(8'($urandom), bs, bp, ps, 0);
      check_status("rnd.frame");
      if ($urandom_range(0, 1) == 1) pop_chk("rnd.pop");
      repeat ($urandom_range(0, CPB)) @(negedge clk);
    end
    while (q_m.size() > 0) pop_chk("rnd.drain");
    check_status("rnd.end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
